// File: rtl/i2c_pkg.sv
// i2c_pkg: state encodings and bus-level constants shared by the I2C master and slave.
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, STOP
  } state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } slave_phase_t;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: single-register I2C target, clocked purely by the bus lines.
module i2c_slave_controller
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = 7'b0101010
) (
  inout wire sda,
  inout wire scl
);
  logic start_tog = 1'b0;
  logic start_seen = 1'b0;
  logic stop_tog = 1'b0;
  logic stop_ref = 1'b0;
  logic sda_low = 1'b0;
  logic rd = 1'b0;
  logic [2:0] cnt = 3'd0;
  logic [7:0] sh = 8'h00;
  logic [7:0] mem = 8'hA5;
  slave_phase_t phase = S_IDLE;
  // a STOP seen since the last START silences the driver until the next START
  assign sda = (sda_low && stop_tog == stop_ref) ? 1'b0 : 1'bz;
  always_ff @(negedge sda) if (scl) start_tog <= ~start_tog;
  always_ff @(posedge sda) if (scl) stop_tog <= ~stop_tog;
  always_ff @(posedge scl) begin
    if (start_tog != start_seen) begin
      start_seen <= start_tog;
      stop_ref <= stop_tog;
      phase <= S_ADDR;
      cnt <= 3'd1;
      sh <= {7'd0, sda};
    end else begin
      cnt <= cnt + 1'b1;
      sh <= {sh[6:0], sda};
      case (phase)
        S_ADDR: if (cnt == 3'd7) begin
          phase <= (sh[6:0] == ADDRESS) ? S_ADDR_ACK : S_IDLE;
          rd <= sda;
        end
        S_ADDR_ACK: begin
          phase <= rd ? S_RD : S_WR;
          cnt <= 3'd0;
        end
        S_WR: if (cnt == 3'd7) begin
          mem <= {sh[6:0], sda};
          phase <= S_WR_ACK;
        end
        S_RD: if (cnt == 3'd7) phase <= S_RD_ACK;
        default: phase <= S_IDLE;
      endcase
    end
  end
  always_ff @(negedge scl)
    sda_low <= phase == S_ADDR_ACK || phase == S_WR_ACK || (phase == S_RD && !mem[~cnt]);
endmodule

// File: rtl/i2c_controller_master.sv
// i2c_controller_master: single-byte I2C read/write master with open-drain SDA
// and push-pull SCL generated by an inline clock divider.
module i2c_controller_master
  import i2c_pkg::*;
#(
  parameter int DIVIDE_BY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);
  localparam int HALF = DIVIDE_BY / 2;
  localparam int CW = $clog2(DIVIDE_BY);
  // SDA moves mid-low, SCL rises at half period and falls at the period end
  localparam logic [CW-1:0] C_SET  = CW'(HALF / 2 - 1);
  localparam logic [CW-1:0] C_RISE = CW'(HALF - 1);
  localparam logic [CW-1:0] C_FALL = CW'(DIVIDE_BY - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh, rx, data_q;
  logic rw_q, scl_q, sda_low, ack_q;
  assign i2c_scl = scl_q;
  assign i2c_sda = sda_low ? 1'b0 : 1'bz;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ready <= 1'b0;
      data_out <= 8'h00;
      scl_q <= 1'b1;
      sda_low <= 1'b0;
      cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      rx <= '0;
      data_q <= '0;
      rw_q <= 1'b0;
      ack_q <= NACK;
    end else if (state == IDLE) begin
      cnt <= '0;
      scl_q <= 1'b1;
      sda_low <= 1'b0;
      if (enable && ready) begin
        sh <= {addr, rw};
        data_q <= data_in;
        rw_q <= rw;
        ready <= 1'b0;
        state <= START;
      end else ready <= 1'b1;
    end else begin
      cnt <= (cnt == C_FALL) ? '0 : cnt + 1'b1;
      if (cnt == C_SET && state != START)
        sda_low <= (state == ADDR || state == WRITE_DATA) ? ~sh[7] : (state == STOP);
      if (cnt == C_RISE) begin
        scl_q <= 1'b1;
        ack_q <= i2c_sda;
        if (state == READ_DATA) rx <= {rx[6:0], i2c_sda};
        if (state == START) sda_low <= 1'b1;
      end
      if (cnt == C_FALL) begin
        scl_q <= state == STOP;
        if (state == ADDR || state == WRITE_DATA) sh <= {sh[6:0], 1'b0};
        if (state == ADDR || state == WRITE_DATA || state == READ_DATA) bit_cnt <= bit_cnt + 1'b1;
        case (state)
          START: begin
            state <= ADDR;
            bit_cnt <= '0;
          end
          ADDR: if (bit_cnt == 3'd7) state <= ADDR_ACK;
          ADDR_ACK: begin
            state <= (ack_q == NACK) ? STOP : rw_q ? READ_DATA : WRITE_DATA;
            sh <= data_q;
          end
          WRITE_DATA: if (bit_cnt == 3'd7) state <= WRITE_ACK;
          WRITE_ACK: state <= STOP;
          READ_DATA: if (bit_cnt == 3'd7) state <= READ_ACK;
          READ_ACK: begin
            data_out <= rx;
            state <= STOP;
          end
          STOP: begin
            sda_low <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_controller_master.sv
// tb_i2c_controller_master: directed checks of the master against the companion slave on a pulled-up bus.
module tb_i2c_controller_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic ready;
  wire i2c_sda, i2c_scl;
  pullup pu_sda (i2c_sda);
  pullup pu_scl (i2c_scl);
  int total = 0, bad = 0, starts = 0, stops = 0, seen = 0, nbit = 0;
  int n = 0, b0 = 0, s0 = 0, p0 = 0, k = 0;
  logic [8:0] mon_sh = 9'd0;
  logic [7:0] bytes[$];
  logic acks[$];

  always #5 clk = ~clk;

  i2c_controller_master #(.DIVIDE_BY(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable), .rw(rw),
    .data_out(data_out), .ready(ready), .i2c_sda(i2c_sda), .i2c_scl(i2c_scl)
  );
  i2c_slave_controller u_slv (.sda(i2c_sda), .scl(i2c_scl));

  always @(negedge i2c_sda) if (i2c_scl === 1'b1) starts++;
  always @(posedge i2c_sda) if (i2c_scl === 1'b1) stops++;
  always @(posedge i2c_scl) begin
    if (starts != seen) begin
      seen = starts;
      nbit = 0;
    end
    mon_sh = {mon_sh[7:0], i2c_sda};
    nbit++;
    if (nbit == 9) begin
      bytes.push_back(mon_sh[8:1]);
      acks.push_back(mon_sh[0]);
      nbit = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic start_txn(input logic [6:0] a, input logic [7:0] d, input logic r);
    b0 = bytes.size();
    s0 = starts;
    p0 = stops;
    addr = a;
    data_in = d;
    rw = r;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("ready_drop", 32'(ready), 32'd0);
  endtask

  task automatic wait_done();
    n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_rise", 32'(ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_scl", 32'(i2c_scl), 32'd1);
    chk("rst_sda", 32'(i2c_sda), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 32'(ready), 32'd1);

    start_txn(7'h2A, 8'hAA, 1'b0);
    wait_done();
    chk("wr_len", 32'(n >= 76 && n <= 84), 32'd1);
    chk("wr_nbytes", 32'(bytes.size() - b0), 32'd2);
    chk("wr_addr", 32'(bytes[b0]), 32'h54);
    chk("wr_aack", 32'(acks[b0]), 32'd0);
    chk("wr_data", 32'(bytes[b0+1]), 32'hAA);
    chk("wr_dack", 32'(acks[b0+1]), 32'd0);
    chk("wr_start", 32'(starts - s0), 32'd1);
    chk("wr_stop", 32'(stops - p0), 32'd1);
    chk("wr_mem", 32'(u_slv.mem), 32'hAA);

    start_txn(7'h2A, 8'h00, 1'b1);
    wait_done();
    chk("rd_len", 32'(n >= 76 && n <= 84), 32'd1);
    chk("rd_addr", 32'(bytes[b0]), 32'h55);
    chk("rd_aack", 32'(acks[b0]), 32'd0);
    chk("rd_bus", 32'(bytes[b0+1]), 32'hAA);
    chk("rd_nack", 32'(acks[b0+1]), 32'd1);
    chk("rd_stop", 32'(stops - p0), 32'd1);
    chk("rd_dout", 32'(data_out), 32'hAA);

    start_txn(7'h15, 8'h77, 1'b0);
    wait_done();
    chk("na_len", 32'(n >= 40 && n <= 48), 32'd1);
    chk("na_nbytes", 32'(bytes.size() - b0), 32'd1);
    chk("na_addr", 32'(bytes[b0]), 32'h2A);
    chk("na_ack", 32'(acks[b0]), 32'd1);
    chk("na_stop", 32'(stops - p0), 32'd1);
    chk("na_mem", 32'(u_slv.mem), 32'hAA);
    chk("na_dout", 32'(data_out), 32'hAA);

    start_txn(7'h2A, 8'h3C, 1'b0);
    repeat (20) @(negedge clk);
    addr = 7'h15;
    data_in = 8'h00;
    rw = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done();
    chk("busy_nbytes", 32'(bytes.size() - b0), 32'd2);
    chk("busy_addr", 32'(bytes[b0]), 32'h54);
    chk("busy_data", 32'(bytes[b0+1]), 32'h3C);
    chk("busy_start", 32'(starts - s0), 32'd1);
    chk("busy_mem", 32'(u_slv.mem), 32'h3C);

    start_txn(7'h2A, 8'h81, 1'b0);
    repeat (45) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_scl", 32'(i2c_scl), 32'd1);
    chk("mid_sda", 32'(i2c_sda), 32'd1);
    chk("mid_ready", 32'(ready), 32'd0);
    chk("mid_dout", 32'(data_out), 32'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(ready), 32'd1);
    chk("mid_mem", 32'(u_slv.mem), 32'h3C);

    k = 0;
    repeat (100) begin
      @(negedge clk);
      if (i2c_scl !== 1'b1 || i2c_sda !== 1'b1 || ready !== 1'b1) k++;
    end
    chk("idle_bus", 32'(k), 32'd0);

    start_txn(7'h2A, 8'h5A, 1'b0);
    wait_done();
    chk("rec_data", 32'(bytes[b0+1]), 32'h5A);
    chk("rec_mem", 32'(u_slv.mem), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
